multicycle_ctrl: RTL

//  Multi-cycle sequencer for the RV32I core with one shared instruction/data memory port.

---
 rtl/multicycle_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer that steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
// It owns the shared memory req/ack handshake, the wait-state timeout and the retired-instruction counter.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [6:0]       i_opcode,
    input  logic             i_br_taken,
    input  logic             i_mem_ack,
    output logic             o_mem_req,
    output logic             o_mem_we,
    output logic             o_addr_sel,
    output logic             o_ir_wren,
    output logic             o_pc_wren,
    output logic             o_pc_sel,
    output logic             o_rd_wren,
    output logic [1:0]       o_wb_sel,
    output logic             o_op_a_sel,
    output logic             o_op_b_sel,
    output logic [1:0]       o_alu_op,
    output logic [2:0]       o_state,
    output logic             o_illegal,
    output logic             o_bus_err,
    output logic [CNT_W-1:0] o_instret
);
    // state  | meaning
    // FETCH  | read instruction at PC, latch IR on ack
    // DECODE | regfile read, opcode legality check
    // EXEC   | ALU operation; branches resolve and retire here
    // MEM    | load/store data access
    // WB     | regfile write and PC update
    // TRAP   | halted after illegal opcode or bus timeout, until reset
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              ack_q;
    logic              timeout;
    logic              is_load, is_store, is_r, is_opimm, is_branch;
    logic              is_jal, is_jalr, is_lui, is_auipc, is_legal;
    logic              sel_a, sel_b;
    logic [1:0]        sel_alu;

    // An ack seen while reset is low must not produce strobes.
    assign ack_q   = i_mem_ack & i_rst_n;
    assign timeout = (MEM_TIMEOUT > 0) && o_mem_req && !ack_q &&
                     (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));
    assign o_state = state;

    always_comb begin
        is_load   = (i_opcode == 7'b0000011);
        is_store  = (i_opcode == 7'b0100011);
        is_r      = (i_opcode == 7'b0110011);
        is_opimm  = (i_opcode == 7'b0010011);
        is_branch = (i_opcode == 7'b1100011);
        is_jal    = (i_opcode == 7'b1101111);
        is_jalr   = (i_opcode == 7'b1100111);
        is_lui    = (i_opcode == 7'b0110111);
        is_auipc  = (i_opcode == 7'b0010111);
        is_legal  = is_load | is_store | is_r | is_opimm | is_branch |
                    is_jal | is_jalr | is_lui | is_auipc;
        sel_a     = is_branch | is_jal | is_auipc;
        sel_b     = !is_r;
        sel_alu   = (is_load | is_store) ? 2'b01 :
                    (is_r | is_opimm)    ? 2'b10 : 2'b00;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state <= S_FETCH;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:  if (ack_q) state_nxt = S_DECODE;
                      else if (timeout) state_nxt = S_TRAP;
            S_DECODE: state_nxt = is_legal ? S_EXEC : S_TRAP;
            S_EXEC:   if (is_branch) state_nxt = S_FETCH;
                      else if (is_load | is_store) state_nxt = S_MEM;
                      else state_nxt = S_WB;
            S_MEM:    if (ack_q) state_nxt = is_store ? S_FETCH : S_WB;
                      else if (timeout) state_nxt = S_TRAP;
            S_WB:     state_nxt = S_FETCH;
            S_TRAP:   state_nxt = S_TRAP;
            default:  state_nxt = S_TRAP;
        endcase
    end

    always_comb begin
        o_mem_req  = 1'b0;
        o_mem_we   = 1'b0;
        o_addr_sel = 1'b0;
        o_ir_wren  = 1'b0;
        o_pc_wren  = 1'b0;
        o_pc_sel   = 1'b0;
        o_rd_wren  = 1'b0;
        o_wb_sel   = 2'b00;
        o_op_a_sel = 1'b0;
        o_op_b_sel = 1'b0;
        o_alu_op   = 2'b00;
        if (state == S_EXEC || state == S_MEM || state == S_WB) begin
            o_op_a_sel = sel_a;
            o_op_b_sel = sel_b;
            o_alu_op   = sel_alu;
        end
        case (state)
            S_FETCH: begin
                o_mem_req = 1'b1;
                o_ir_wren = ack_q;
            end
            S_EXEC: begin
                o_pc_wren = is_branch;
                o_pc_sel  = is_branch & i_br_taken;
            end
            S_MEM: begin
                o_mem_req  = 1'b1;
                o_addr_sel = 1'b1;
                o_mem_we   = is_store;
                o_pc_wren  = ack_q & is_store;
            end
            S_WB: begin
                o_rd_wren = 1'b1;
                o_pc_wren = 1'b1;
                o_pc_sel  = is_jal | is_jalr;
                o_wb_sel  = is_load ? 2'b10 : (is_jal | is_jalr) ? 2'b00 : 2'b01;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wait_cnt  <= '0;
            o_illegal <= 1'b0;
            o_bus_err <= 1'b0;
            o_instret <= '0;
        end else begin
            if (ack_q || !o_mem_req || timeout) wait_cnt <= '0;
            else                                wait_cnt <= wait_cnt + 1'b1;
            if (state == S_DECODE && !is_legal) o_illegal <= 1'b1;
            if (timeout)                        o_bus_err <= 1'b1;
            if (o_pc_wren)                      o_instret <= o_instret + 1'b1;
        end
    end
endmodule
